// File: rtl/rename_pkg.sv
// Shared types and sizing constants for the rename / dispatch front end.
// Register ids and ROB tags are 4 bits; operands are 16 bits.
package rename_pkg;

    localparam int WIDTH       = 4;
    localparam int ROB_DEPTH   = 16;
    localparam int ROB_MAX_OCC = 15;
    localparam int NUM_REGS    = 16;
    localparam int DATA_W      = 16;

    typedef logic [3:0]        tag_t;
    typedef logic [3:0]        reg_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } rat_entry_t;

    // One renamed source operand.
    typedef struct packed {
        tag_t  tag;
        logic  rdy;
        logic  rf;
        data_t val;
    } src_t;

endpackage

// File: rtl/rename_rat.sv
// Register alias table: 16 entries, 8 combinational read ports,
// 4 rename write ports, 4 commit-clear ports and a flush.
// Ports: rd_reg/rd_valid/rd_tag (8 reads), wr_* (rename), clr_* (commit),
// flush; clk, rst_n async active-low.
module rename_rat
    import rename_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] rd_reg,
    output logic [7:0]  rd_valid,
    output logic [31:0] rd_tag,
    input  logic [3:0]  wr_en,
    input  logic [15:0] wr_reg,
    input  logic [15:0] wr_tag,
    input  logic [3:0]  clr_en,
    input  logic [15:0] clr_reg,
    input  logic [15:0] clr_tag
);

    rat_entry_t rat_q [NUM_REGS];
    rat_entry_t rat_d [NUM_REGS];

    always_comb begin
        for (int p = 0; p < 8; p++) begin
            rd_valid[p]     = rat_q[rd_reg[4*p +: 4]].valid;
            rd_tag[4*p +: 4] = rat_q[rd_reg[4*p +: 4]].tag;
        end
    end

    // Commit clears are judged against the current table, then rename
    // writes override them; a higher write slot overrides a lower one.
    always_comb begin
        rat_d = rat_q;
        for (int l = 0; l < WIDTH; l++) begin
            if (clr_en[l] && rat_q[clr_reg[4*l +: 4]].valid &&
                rat_q[clr_reg[4*l +: 4]].tag == clr_tag[4*l +: 4])
                rat_d[clr_reg[4*l +: 4]].valid = 1'b0;
        end
        for (int w = 0; w < WIDTH; w++) begin
            if (wr_en[w]) begin
                rat_d[wr_reg[4*w +: 4]].valid = 1'b1;
                rat_d[wr_reg[4*w +: 4]].tag   = wr_tag[4*w +: 4];
            end
        end
        if (flush) begin
            for (int e = 0; e < NUM_REGS; e++)
                rat_d[e].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rat_q <= '{default: '0};
        else
            rat_q <= rat_d;
    end

endmodule

// File: rtl/rename_dispatch.sv
// Rename/dispatch stage feeding a 16-entry ROB: up to 4 ops per cycle get
// consecutive ROB tags, renamed sources and a one-cycle registered output.
// Inputs: in_valid/in_count/in_dst/in_src_a/b, flush, rob_size,
// rob_finished, rob_values, commit_en/reg/tag. Outputs: in_ready,
// alloc_count/targets, out_valid, out_tag, out_src_tag/rdy/rf/val_a/b.
// Optional macro RENAME_BYPASS_EN: forward finished ROB results to sources.
module rename_dispatch
    import rename_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [2:0]   in_count,
    input  logic [15:0]  in_dst,
    input  logic [15:0]  in_src_a,
    input  logic [15:0]  in_src_b,
    output logic         in_ready,
    input  logic         flush,
    input  logic [3:0]   rob_size,
    input  logic [15:0]  rob_finished,
    input  logic [255:0] rob_values,
    input  logic [3:0]   commit_en,
    input  logic [15:0]  commit_reg,
    input  logic [15:0]  commit_tag,
    output logic [2:0]   alloc_count,
    output logic [15:0]  alloc_targets,
    output logic         out_valid,
    output logic [15:0]  out_tag,
    output logic [15:0]  out_src_tag_a,
    output logic [15:0]  out_src_tag_b,
    output logic [3:0]   out_src_rdy_a,
    output logic [3:0]   out_src_rdy_b,
    output logic [3:0]   out_src_rf_a,
    output logic [3:0]   out_src_rf_b,
    output logic [63:0]  out_src_val_a,
    output logic [63:0]  out_src_val_b
);

    tag_t        tag_head;
    logic [4:0]  occ;
    logic [2:0]  cnt;
    logic        accept;
    logic [3:0]  wr_en;
    logic [15:0] wr_tag;
    logic [7:0]  rat_valid;
    logic [31:0] rat_tag;
    src_t        sa [WIDTH];
    src_t        sb [WIDTH];

    // Occupancy includes the group still in flight to the ROB; a full
    // group must fit under 15 so in_count is not needed here.
    assign occ      = {1'b0, rob_size} + {2'b0, alloc_count};
    assign in_ready = rst_n && !flush &&
                      (occ <= 5'(ROB_MAX_OCC - WIDTH));
    assign cnt      = (in_count > 3'(WIDTH)) ? 3'(WIDTH) : in_count;
    assign accept   = in_valid && in_ready && (in_count != 3'd0);

    always_comb begin
        wr_en  = '0;
        wr_tag = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_en[i]          = accept && (3'(i) < cnt);
            wr_tag[4*i +: 4]  = tag_head + tag_t'(i);
        end
    end

`ifndef RENAME_BYPASS_EN
    logic unused_rob;
    assign unused_rob = ^{rob_finished, rob_values};
`endif

    function automatic src_t map_src(input int i, input reg_t s,
                                     input logic rv, input tag_t rt);
        src_t r;
        r     = '0;
        r.rf  = 1'b1;
        r.rdy = 1'b1;
        if (rv) begin
            r.rf  = 1'b0;
            r.rdy = 1'b0;
            r.tag = rt;
`ifdef RENAME_BYPASS_EN
            if (rob_finished[rt]) begin
                r.rdy = 1'b1;
                r.val = rob_values[{rt, 4'h0} +: 16];
            end
`endif
        end
        // Later matches override earlier ones: nearest producer wins.
        for (int j = 0; j < WIDTH; j++) begin
            if (j < i && in_dst[4*j +: 4] == s) begin
                r.tag = tag_head + tag_t'(j);
                r.rdy = 1'b0;
                r.rf  = 1'b0;
                r.val = '0;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            sa[i] = map_src(i, in_src_a[4*i +: 4], rat_valid[i],
                            rat_tag[4*i +: 4]);
            sb[i] = map_src(i, in_src_b[4*i +: 4], rat_valid[i+4],
                            rat_tag[4*(i+4) +: 4]);
        end
    end

    rename_rat u_rat (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .rd_reg  ({in_src_b, in_src_a}),
        .rd_valid(rat_valid),
        .rd_tag  (rat_tag),
        .wr_en   (wr_en),
        .wr_reg  (in_dst),
        .wr_tag  (wr_tag),
        .clr_en  (commit_en),
        .clr_reg (commit_reg),
        .clr_tag (commit_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_head      <= '0;
            alloc_count   <= '0;
            alloc_targets <= '0;
            out_valid     <= 1'b0;
            out_tag       <= '0;
            out_src_tag_a <= '0;
            out_src_tag_b <= '0;
            out_src_rdy_a <= '0;
            out_src_rdy_b <= '0;
            out_src_rf_a  <= '0;
            out_src_rf_b  <= '0;
            out_src_val_a <= '0;
            out_src_val_b <= '0;
        end else begin
            alloc_count   <= '0;
            alloc_targets <= '0;
            out_valid     <= 1'b0;
            out_tag       <= '0;
            out_src_tag_a <= '0;
            out_src_tag_b <= '0;
            out_src_rdy_a <= '0;
            out_src_rdy_b <= '0;
            out_src_rf_a  <= '0;
            out_src_rf_b  <= '0;
            out_src_val_a <= '0;
            out_src_val_b <= '0;
            if (accept) begin
                tag_head      <= tag_head + tag_t'(cnt);
                alloc_count   <= cnt;
                alloc_targets <= in_dst;
                out_valid     <= 1'b1;
                out_tag       <= wr_tag;
                for (int i = 0; i < WIDTH; i++) begin
                    out_src_tag_a[4*i +: 4]  <= sa[i].tag;
                    out_src_tag_b[4*i +: 4]  <= sb[i].tag;
                    out_src_rdy_a[i]         <= sa[i].rdy;
                    out_src_rdy_b[i]         <= sb[i].rdy;
                    out_src_rf_a[i]          <= sa[i].rf;
                    out_src_rf_b[i]          <= sb[i].rf;
                    out_src_val_a[16*i +: 16] <= sa[i].val;
                    out_src_val_b[16*i +: 16] <= sb[i].val;
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_dispatch.sv
// Self-checking bench for rename_dispatch: directed steps followed by
// random traffic, compared against an array-based rename model.
module tb_rename_dispatch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   in_count;
    logic [15:0]  in_dst, in_src_a, in_src_b;
    logic         in_ready;
    logic         flush;
    logic [3:0]   rob_size;
    logic [15:0]  rob_finished;
    logic [255:0] rob_values;
    logic [3:0]   commit_en;
    logic [15:0]  commit_reg, commit_tag;
    logic [2:0]   alloc_count;
    logic [15:0]  alloc_targets;
    logic         out_valid;
    logic [15:0]  out_tag, out_src_tag_a, out_src_tag_b;
    logic [3:0]   out_src_rdy_a, out_src_rdy_b;
    logic [3:0]   out_src_rf_a, out_src_rf_b;
    logic [63:0]  out_src_val_a, out_src_val_b;

    int nchk = 0;
    int nfail = 0;

    int m_valid [16];
    int m_tag [16];
    int m_head;
    int m_alloc;

    always #5 clk = ~clk;

    rename_dispatch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_count(in_count),
        .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_ready(in_ready), .flush(flush), .rob_size(rob_size),
        .rob_finished(rob_finished), .rob_values(rob_values),
        .commit_en(commit_en), .commit_reg(commit_reg),
        .commit_tag(commit_tag),
        .alloc_count(alloc_count), .alloc_targets(alloc_targets),
        .out_valid(out_valid), .out_tag(out_tag),
        .out_src_tag_a(out_src_tag_a), .out_src_tag_b(out_src_tag_b),
        .out_src_rdy_a(out_src_rdy_a), .out_src_rdy_b(out_src_rdy_b),
        .out_src_rf_a(out_src_rf_a), .out_src_rf_b(out_src_rf_b),
        .out_src_val_a(out_src_val_a), .out_src_val_b(out_src_val_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, {63'd0, in_ready}, 0);
        chk({tag, "_ov"}, {63'd0, out_valid}, 0);
        chk({tag, "_ac"}, {61'd0, alloc_count}, 0);
        chk({tag, "_at"}, {48'd0, alloc_targets}, 0);
        chk({tag, "_tag"}, {48'd0, out_tag}, 0);
        chk({tag, "_st"}, {32'd0, out_src_tag_a, out_src_tag_b}, 0);
        chk({tag, "_fl"}, {48'd0, out_src_rdy_a, out_src_rdy_b,
                           out_src_rf_a, out_src_rf_b}, 0);
        chk({tag, "_va"}, out_src_val_a, 0);
        chk({tag, "_vb"}, out_src_val_b, 0);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_valid[r] = 0;
            m_tag[r] = 0;
        end
        m_head = 0;
        m_alloc = 0;
    endtask

    task automatic model_src(input int i, input int s, output int tag,
                             output int rdy, output int rf, output int val);
        bit found;
        tag = 0; rdy = 1; rf = 1; val = 0;
        if (m_valid[s] != 0) begin
            tag = m_tag[s]; rdy = 0; rf = 0;
`ifdef RENAME_BYPASS_EN
            if (rob_finished[tag]) begin
                rdy = 1;
                val = int'(rob_values[tag*16 +: 16]);
            end
`endif
        end
        found = 0;
        for (int j = i - 1; j >= 0; j--) begin
            if (!found && int'(in_dst[4*j +: 4]) == s) begin
                found = 1;
                tag = (m_head + j) % 16;
                rdy = 0; rf = 0; val = 0;
            end
        end
    endtask

    // One clock: check in_ready, predict outputs, tick, compare, update.
    task automatic cycle();
        int rs, exp_rdy, cnt, acc;
        int et [4], ta [4], ra [4], fa [4], va [4];
        int tb_ [4], rb [4], fb [4], vb [4];
        int ov [16], ot [16];
        #2;
        rs = int'(rob_size);
        exp_rdy = (!flush && (15 - rs - m_alloc >= 4)) ? 1 : 0;
        chk("in_ready", {63'd0, in_ready}, exp_rdy);
        cnt = (int'(in_count) > 4) ? 4 : int'(in_count);
        acc = (in_valid && exp_rdy == 1 && cnt > 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            et[i] = (m_head + i) % 16;
            model_src(i, int'(in_src_a[4*i +: 4]), ta[i], ra[i], fa[i], va[i]);
            model_src(i, int'(in_src_b[4*i +: 4]), tb_[i], rb[i], fb[i], vb[i]);
        end
        @(posedge clk);
        #1;
        chk("out_valid", {63'd0, out_valid}, acc);
        chk("alloc_count", {61'd0, alloc_count}, acc != 0 ? cnt : 0);
        if (acc != 0) begin
            for (int i = 0; i < cnt; i++) begin
                chk($sformatf("target%0d", i), alloc_targets[4*i +: 4],
                    in_dst[4*i +: 4]);
                chk($sformatf("tag%0d", i), out_tag[4*i +: 4], et[i]);
                chk($sformatf("stag_a%0d", i), out_src_tag_a[4*i +: 4], ta[i]);
                chk($sformatf("stag_b%0d", i), out_src_tag_b[4*i +: 4], tb_[i]);
                chk($sformatf("rdy_a%0d", i), out_src_rdy_a[i], ra[i]);
                chk($sformatf("rdy_b%0d", i), out_src_rdy_b[i], rb[i]);
                chk($sformatf("rf_a%0d", i), out_src_rf_a[i], fa[i]);
                chk($sformatf("rf_b%0d", i), out_src_rf_b[i], fb[i]);
                chk($sformatf("val_a%0d", i), out_src_val_a[16*i +: 16], va[i]);
                chk($sformatf("val_b%0d", i), out_src_val_b[16*i +: 16], vb[i]);
            end
        end
        if (flush) begin
            for (int r = 0; r < 16; r++) m_valid[r] = 0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                ov[r] = m_valid[r];
                ot[r] = m_tag[r];
            end
            for (int l = 0; l < 4; l++) begin
                if (commit_en[l] && ov[commit_reg[4*l +: 4]] != 0 &&
                    ot[commit_reg[4*l +: 4]] == int'(commit_tag[4*l +: 4]))
                    m_valid[commit_reg[4*l +: 4]] = 0;
            end
            if (acc != 0) begin
                for (int i = 0; i < cnt; i++) begin
                    m_valid[in_dst[4*i +: 4]] = 1;
                    m_tag[in_dst[4*i +: 4]] = (m_head + i) % 16;
                end
                m_head = (m_head + cnt) % 16;
            end
        end
        m_alloc = (acc != 0) ? cnt : 0;
    endtask

    task automatic grp(input int n, input logic [15:0] d,
                       input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_count = 3'(n);
        in_dst = d;
        in_src_a = a;
        in_src_b = b;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_count = 0; in_dst = 0; in_src_a = 0; in_src_b = 0;
        flush = 0; rob_size = 0; rob_finished = 0; rob_values = 0;
        commit_en = 0; commit_reg = 0; commit_tag = 0;
        model_reset();
        #3;
        chk_zero("reset");
        #9 rst_n = 1'b1;

        // 1: three independent ops from reset.
        grp(3, 16'h0321, 16'h0000, 16'h0000);
        cycle();
        chk("t1_tags", {52'd0, out_tag[11:0]}, 64'h210);
        chk("t1_rf", {60'd0, out_src_rf_a[2:0], 1'b0}, 64'he);

        // 2: r5=r1+r1; r6=r5+r5 -> slot1 forwards from slot0.
        grp(2, 16'h0065, 16'h0051, 16'h0051);
        cycle();
        chk("t2_fwd_tag", out_src_tag_a[7:4], 3);
        chk("t2_fwd_rdy", {62'd0, out_src_rdy_a[1], out_src_rf_a[1]}, 0);

        // 3: capacity limits.
        in_valid = 0;
        cycle();
        rob_size = 12;
        cycle();
        chk("t3_full", in_ready, 0);
        rob_size = 11;
        cycle();
        rob_size = 8;
        grp(4, 16'hA987, 16'h0000, 16'h0000);
        cycle();
        cycle();
        chk("t3_refused", out_valid, 0);
        in_valid = 0;
        rob_size = 0;
        cycle();

        // 4: commit vs same-cycle rename of r2.
        grp(1, 16'h0002, 16'h0000, 16'h0000);
        cycle();
        chk("t4_tag9", out_tag[3:0], 9);
        commit_en = 4'b0001; commit_reg = 16'h0002; commit_tag = 16'h0009;
        cycle();
        commit_en = 0;
        grp(1, 16'h000B, 16'h0002, 16'h0000);
        cycle();
        chk("t4_keep", {59'd0, out_src_tag_a[3:0], out_src_rf_a[0]}, 64'h14);
        in_valid = 0;
        commit_en = 4'b0100; commit_reg = 16'h0200; commit_tag = 16'h0900;
        cycle();
        commit_tag = 16'h0A00;
        cycle();
        commit_en = 0;
        grp(1, 16'h000C, 16'h0002, 16'h0000);
        cycle();
        chk("t4_rf", out_src_rf_a[0], 1);

        // 5+6: r4 -> tag 13, bypass from ROB; group wraps 14,15,0,1.
        grp(1, 16'h0004, 16'h0000, 16'h0000);
        cycle();
        rob_finished = 16'h2000;
        rob_values[13*16 +: 16] = 16'hBEEF;
        grp(4, 16'h3216, 16'h0064, 16'h0000);
        cycle();
        chk("t6_wrap", out_tag, 16'h10FE);
        chk("t6_fwd", out_src_tag_a[7:4], 14);
`ifdef RENAME_BYPASS_EN
        chk("t5_byp", {out_src_rdy_a[0], out_src_val_a[15:0]}, 17'h1BEEF);
`else
        chk("t5_byp", {out_src_rdy_a[0], out_src_val_a[15:0]}, 17'h00000);
`endif

        // flush concurrent with a group; then all registers read rf.
        flush = 1'b1;
        grp(4, 16'h1111, 16'h0000, 16'h0000);
        cycle();
        chk("t6_flush", out_valid, 0);
        flush = 1'b0;
        grp(4, 16'h0000, 16'h3210, 16'h7654);
        cycle();
        chk("t6_rf_lo", {out_src_rf_a, out_src_rf_b}, 8'hFF);
        grp(4, 16'h0000, 16'hBA98, 16'hFEDC);
        cycle();
        chk("t6_rf_hi", {out_src_rf_a, out_src_rf_b}, 8'hFF);

        // async reset while a group is registered.
        grp(4, 16'h4321, 16'h1234, 16'h0000);
        cycle();
        chk("t6_pre", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        in_valid = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom % 4) != 0;
            in_count = 3'($urandom % 8);
            in_dst = 16'($urandom);
            in_src_a = 16'($urandom);
            in_src_b = 16'($urandom);
            flush = ($urandom % 20) == 0;
            rob_size = 4'($urandom % 13);
            rob_finished = 16'($urandom);
            for (int k = 0; k < 16; k++)
                rob_values[16*k +: 16] = 16'($urandom);
            for (int l = 0; l < 4; l++) begin
                int r;
                r = $urandom % 16;
                commit_en[l] = ($urandom % 2) != 0;
                commit_reg[4*l +: 4] = 4'(r);
                commit_tag[4*l +: 4] = ($urandom % 4 != 0) ?
                    4'(m_tag[r]) : 4'($urandom);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
